bus_coherence_ctrl: RTL and testbench
=====================================

BUS_COHERENCE_CTRL -- requirements
Module: bus_coherence_ctrl

Interface
REQ-001 Parameter CPUS, 2, number of cached cores (2..8).
REQ-002 Parameter BLOCK_WORDS, 2, words per cache block (power of two, 1..8).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 iREN  in  [CPUS]  instruction fetch request.
REQ-006 iaddr  in  [CPUS] x 32  fetch word address.
REQ-007 iload  out  [CPUS] x 32  fetch data.
REQ-008 iwait  out  [CPUS]  fetch stall, low one cycle per completed word.
REQ-009 dREN  in  [CPUS]  data block read (miss fill).
REQ-010 dWEN  in  [CPUS]  data block write (dirty eviction).
REQ-011 daddr  in  [CPUS] x 32  current data word address.
REQ-012 dstore  in  [CPUS] x 32  eviction or snoop-supply data.
REQ-013 dload  out  [CPUS] x 32  fill data.
REQ-014 dwait  out  [CPUS]  data stall, low one cycle per completed word.
REQ-015 cctrans  in  [CPUS]  coherence transaction pending.
REQ-016 ccwrite  in  [CPUS]  requester: intent to modify; snooped cache: holds block Modified.
REQ-017 ccwait  out  [CPUS]  snoop in progress, cache must respond.
REQ-018 ccinv  out  [CPUS]  invalidate snooped block.
REQ-019 ccsnoopaddr  out  [CPUS] x 32  snoop address.
REQ-020 ramREN, ramWEN  out  1 each  RAM read/write strobes, never both high.
REQ-021 ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-022 ramload  in  32  RAM read data.
REQ-023 ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR; word done only on ACCESS.

Function
REQ-024 States: IDLE, WB, SNOOP, C2C, RAMREAD, IFETCH; combinational outputs default low except all iwait/dwait high.
REQ-025 IDLE: data requester = (dREN|dWEN) or cctrans; grant the first data requester after data pointer (round-robin); else first iREN after instruction pointer; grant and pointer registered, word counter cleared.
REQ-026 Data always beats instruction; a waiting core is granted within CPUS data transactions.
REQ-027 Granted dWEN -> WB: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g], no snoop.
REQ-028 Granted dREN -> SNOOP for exactly one cycle: for all j!=g, ccwait[j]=1, ccsnoopaddr[j]=daddr[g], ccinv[j]=ccwrite[g].
REQ-029 SNOOP exit: lowest-index j!=g with ccwrite[j] is registered as supplier -> C2C; none -> RAMREAD.
REQ-030 C2C: dload[g]=dstore[s], ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s], ccwait[s] held high; dwait[g], dwait[s] low on ACCESS.
REQ-031 RAMREAD: ramREN=1, ramaddr=daddr[g], dload[g]=ramload, dwait[g] low on ACCESS.
REQ-032 IFETCH: ramREN=1, ramaddr=iaddr[g], iload[g]=ramload, iwait[g] low on ACCESS; one word per grant.
REQ-033 Each ACCESS increments word counter; after BLOCK_WORDS ACCESS cycles (wrap to 0) return to IDLE; BUSY/FREE/ERROR stall, no counter change.
REQ-034 Granted request deasserted mid-block -> abort to IDLE next cycle, no further RAM strobe.
REQ-035 Requests arriving while busy are held pending; no output of an ungranted core changes.

Reset
REQ-036 nRST low: state IDLE, counter 0, both pointers CPUS-1 (core 0 served first), supplier 0; outputs at REQ-024 defaults within the same cycle, including mid-transaction.

Structure
REQ-037 ramstate_t, word_t and the state enum live in cpu_types_pkg; CPUS/BLOCK_WORDS are module parameters.
REQ-038 Sub-module rr_arbiter (parametrised request vector, pointer in, one-hot grant out) instantiated twice (data, instruction).

Verification
REQ-039 CPUS=2: dREN[0],dREN[1] same cycle, no ccwrite -> core 0 gets 2 words from RAM, then core 1; dwait lows in that order.
REQ-040 Core 1 dREN+ccwrite to 0x100, core 0 ccwrite=1 -> ccinv[0]=1 in SNOOP; dload[1]=dstore[0]=0xDEADBEEF; RAM written at 0x100.
REQ-041 dWEN[0] 0x200 data 0x11/0x22, ramstate BUSY 3 cycles per word -> exactly 2 ACCESS writes, dwait[0] low twice.
REQ-042 iREN[0],dREN[1] together -> data first; iwait[0] low only after dwait[1] second low.
REQ-043 nRST low during RAMREAD word 1 -> all strobes low immediately; after release core 0 wins a tie.
REQ-044 CPUS=4, BLOCK_WORDS=4, all cores dREN continuously -> grants 0,1,2,3,0 each of 4 words.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the multi-core bus coherence controller: RAM handshake,
// bus word, and controller state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    SNOOP   = 3'd2,
    C2C     = 3'd3,
    RAMREAD = 3'd4,
    IFETCH  = 3'd5
  } bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester strictly after ptr (wrapping) wins;
// grant is one-hot, or all zero when nobody requests.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [IW-1:0] sel_s;

  // Scan from farthest to nearest so the nearest requester overwrites earlier hits.
  always_comb begin
    grant = '0;
    sel_s = '0;
    for (int k = N; k >= 1; k--) begin
      sel_s = IW'((int'(ptr) + k) % N);
      if (req[sel_s]) begin
        grant        = '0;
        grant[sel_s] = 1'b1;
      end else begin
        grant = grant;
      end
    end
  end

endmodule

// File: rtl/bus_coherence_ctrl.sv
// Snooping bus controller: arbitrates data (write-back, miss fill) and
// instruction fetches from CPUS cores onto one RAM, with cache-to-cache supply.
module bus_coherence_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [CPUS-1:0]    iREN,
  input  logic [CPUS*32-1:0] iaddr,
  output logic [CPUS*32-1:0] iload,
  output logic [CPUS-1:0]    iwait,
  input  logic [CPUS-1:0]    dREN,
  input  logic [CPUS-1:0]    dWEN,
  input  logic [CPUS*32-1:0] daddr,
  input  logic [CPUS*32-1:0] dstore,
  output logic [CPUS*32-1:0] dload,
  output logic [CPUS-1:0]    dwait,
  input  logic [CPUS-1:0]    cctrans,
  input  logic [CPUS-1:0]    ccwrite,
  output logic [CPUS-1:0]    ccwait,
  output logic [CPUS-1:0]    ccinv,
  output logic [CPUS*32-1:0] ccsnoopaddr,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [31:0]        ramaddr,
  output logic [31:0]        ramstore,
  input  logic [31:0]        ramload,
  input  ramstate_t          ramstate
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  bus_state_t    state_r, state_s;
  logic [IW-1:0] gnt_r, gnt_s, dptr_r, dptr_s, iptr_r, iptr_s, sup_r, sup_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [CPUS-1:0] dreq_s, dgnt_s, igrant_s;
  logic [IW-1:0] dsel_s, isel_s, sup_idx_s;
  logic          sup_hit_s, acc_s, last_s;

  function automatic logic [IW-1:0] to_idx(input logic [CPUS-1:0] oh);
    logic [IW-1:0] r;
    r = '0;
    for (int k = 0; k < CPUS; k++) begin
      r = oh[k] ? IW'(k) : r;
    end
    return r;
  endfunction

  assign dreq_s = dREN | dWEN | cctrans;
  assign dsel_s = to_idx(dgnt_s);
  assign isel_s = to_idx(igrant_s);
  assign acc_s  = (ramstate == ACCESS);
  assign last_s = (cnt_r == CW'(BLOCK_WORDS - 1));

  rr_arbiter #(.N(CPUS)) u_darb (.req(dreq_s), .ptr(dptr_r), .grant(dgnt_s));
  rr_arbiter #(.N(CPUS)) u_iarb (.req(iREN),   .ptr(iptr_r), .grant(igrant_s));

  // Lowest-index snooped core reporting a Modified copy becomes the supplier.
  always_comb begin
    sup_hit_s = 1'b0;
    sup_idx_s = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      sup_hit_s = (ccwrite[j] && (IW'(j) != gnt_r)) ? 1'b1 : sup_hit_s;
      sup_idx_s = (ccwrite[j] && (IW'(j) != gnt_r)) ? IW'(j) : sup_idx_s;
    end
  end

  // Next-state and bus outputs; a dropped request aborts with no RAM strobe.
  always_comb begin
    state_s = state_r;
    gnt_s = gnt_r;
    dptr_s = dptr_r;
    iptr_s = iptr_r;
    sup_s = sup_r;
    cnt_s = cnt_r;
    iload = '0;
    iwait = '1;
    dload = '0;
    dwait = '1;
    ccwait = '0;
    ccinv = '0;
    ccsnoopaddr = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = 32'h0;
    ramstore = 32'h0;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (|dreq_s) begin
          gnt_s   = dsel_s;
          dptr_s  = dsel_s;
          state_s = dWEN[dsel_s] ? WB : SNOOP;
        end else if (|iREN) begin
          gnt_s   = isel_s;
          iptr_s  = isel_s;
          state_s = IFETCH;
        end else begin
          state_s = IDLE;
        end
      end
      WB: begin
        if (!dWEN[gnt_r]) begin
          state_s = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[32*gnt_r +: 32];
          ramstore = dstore[32*gnt_r +: 32];
          dwait[gnt_r] = !acc_s;
          cnt_s   = (acc_s && last_s) ? '0 : (acc_s ? cnt_r + CW'(1) : cnt_r);
          state_s = (acc_s && last_s) ? IDLE : WB;
        end
      end
      SNOOP: begin
        for (int j = 0; j < CPUS; j++) begin
          if (IW'(j) != gnt_r) begin
            ccwait[j] = 1'b1;
            ccinv[j]  = ccwrite[gnt_r];
            ccsnoopaddr[32*j +: 32] = daddr[32*gnt_r +: 32];
          end else begin
            ccwait[j] = 1'b0;
          end
        end
        sup_s = sup_hit_s ? sup_idx_s : sup_r;
        if (!dREN[gnt_r]) state_s = IDLE;
        else state_s = sup_hit_s ? C2C : RAMREAD;
      end
      C2C: begin
        if (!dREN[gnt_r]) begin
          state_s = IDLE;
        end else begin
          dload[32*gnt_r +: 32] = dstore[32*sup_r +: 32];
          ramWEN   = 1'b1;
          ramaddr  = daddr[32*sup_r +: 32];
          ramstore = dstore[32*sup_r +: 32];
          ccwait[sup_r] = 1'b1;
          dwait[gnt_r]  = !acc_s;
          dwait[sup_r]  = !acc_s;
          cnt_s   = (acc_s && last_s) ? '0 : (acc_s ? cnt_r + CW'(1) : cnt_r);
          state_s = (acc_s && last_s) ? IDLE : C2C;
        end
      end
      RAMREAD: begin
        if (!dREN[gnt_r]) begin
          state_s = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = daddr[32*gnt_r +: 32];
          dload[32*gnt_r +: 32] = ramload;
          dwait[gnt_r] = !acc_s;
          cnt_s   = (acc_s && last_s) ? '0 : (acc_s ? cnt_r + CW'(1) : cnt_r);
          state_s = (acc_s && last_s) ? IDLE : RAMREAD;
        end
      end
      IFETCH: begin
        if (!iREN[gnt_r]) begin
          state_s = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr[32*gnt_r +: 32];
          iload[32*gnt_r +: 32] = ramload;
          iwait[gnt_r] = !acc_s;
          state_s = acc_s ? IDLE : IFETCH;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Controller state; pointers start at CPUS-1 so core 0 wins the first tie.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      dptr_r  <= IW'(CPUS - 1);
      iptr_r  <= IW'(CPUS - 1);
      sup_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      dptr_r  <= dptr_s;
      iptr_r  <= iptr_s;
      sup_r   <= sup_s;
      cnt_r   <= cnt_s;
    end
  end

endmodule

// File: tb/tb_bus_coherence_ctrl.sv
// Self-checking bench: a 2-core/2-word controller exercised by scenario tasks
// and random rounds, plus a 4-core/4-word instance for round-robin fairness.
module tb_bus_coherence_ctrl;
  import cpu_types_pkg::*;

  localparam logic [31:0] RAM_KEY = 32'hC0DE_F00D;
  localparam int BW = 2;

  logic CLK = 1'b0;
  logic nRST;

  logic [1:0]  iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
  logic [63:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  logic [3:0]   iREN4, iwait4, dREN4, dWEN4, dwait4, cctrans4, ccwrite4, ccwait4, ccinv4;
  logic [127:0] iaddr4, iload4, daddr4, dstore4, dload4, ccsnoopaddr4;
  logic         ramREN4, ramWEN4;
  logic [31:0]  ramaddr4, ramstore4, ramload4;
  ramstate_t    ramstate4;

  // RAM model: every word reads back as its address scrambled by a key.
  assign ramload  = ramaddr ^ RAM_KEY;
  assign ramload4 = ramaddr4 ^ RAM_KEY;

  bus_coherence_ctrl #(.CPUS(2), .BLOCK_WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  bus_coherence_ctrl #(.CPUS(4), .BLOCK_WORDS(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .iREN(iREN4), .iaddr(iaddr4), .iload(iload4), .iwait(iwait4),
    .dREN(dREN4), .dWEN(dWEN4), .daddr(daddr4), .dstore(dstore4), .dload(dload4), .dwait(dwait4),
    .cctrans(cctrans4), .ccwrite(ccwrite4), .ccwait(ccwait4), .ccinv(ccinv4),
    .ccsnoopaddr(ccsnoopaddr4), .ramREN(ramREN4), .ramWEN(ramWEN4), .ramaddr(ramaddr4),
    .ramstore(ramstore4), .ramload(ramload4), .ramstate(ramstate4)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural core model: each core has at most one block transaction.
  logic        active [2];
  logic        is_wr [2];
  logic        ccw [2];
  logic        cct [2];
  logic [31:0] base [2];
  int          wcnt [2];
  logic [31:0] wdata [2][8];
  int          last_d;
  int          rs_mode;
  int          busy_run;
  int          wr_acc;

  task automatic clear_cores();
    for (int c = 0; c < 2; c++) begin
      active[c] = 1'b0; is_wr[c] = 1'b0; ccw[c] = 1'b0; cct[c] = 1'b0;
      base[c] = 32'h0; wcnt[c] = 0;
    end
  endtask

  task automatic pick_ramstate();
    int r;
    if (rs_mode == 0) begin
      ramstate = ACCESS;
    end else if (rs_mode == 1) begin
      ramstate = (busy_run < 3) ? BUSY : ACCESS;
      busy_run = (busy_run < 3) ? busy_run + 1 : 0;
    end else begin
      r = $urandom_range(0, 9);
      ramstate = (r < 5) ? ACCESS : (r < 8) ? BUSY : (r == 8) ? FREE : ERROR;
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < 2; c++) begin
      dREN[c]    = active[c] && !is_wr[c];
      dWEN[c]    = active[c] && is_wr[c];
      cctrans[c] = active[c] && cct[c];
      ccwrite[c] = ccw[c];
      daddr[32*c +: 32]  = base[c] + wcnt[c];
      dstore[32*c +: 32] = wdata[c][wcnt[c] % 8];
    end
    pick_ramstate();
  endtask

  // Runs all active cores to completion; service order is round-robin after last_d.
  task automatic run_data_round(input int budget);
    int order_q[$];
    int cyc;
    logic [31:0] ea;
    order_q = {};
    cyc = 0;
    wr_acc = 0;
    for (int k = 1; k <= 2; k++) begin
      if (active[(last_d + k) % 2]) order_q.push_back((last_d + k) % 2);
    end
    while (order_q.size() > 0 && cyc < budget) begin
      @(posedge CLK); #1;
      drive_inputs();
      @(negedge CLK);
      cyc++;
      if (ramWEN && ramstate == ACCESS) wr_acc++;
      n_checks++;
      if (ramREN && ramWEN) begin
        n_fail++;
        $display("FAIL strobes: ramREN=%b ramWEN=%b, both high", ramREN, ramWEN);
      end
      for (int c = 0; c < 2; c++) begin
        if (!dwait[c]) begin
          ea = base[c] + wcnt[c];
          n_checks++;
          if (ramstate != ACCESS || order_q.size() == 0 || c != order_q[0]) begin
            n_fail++;
            $display("FAIL order: dwait low for core %0d (ramstate %0d), expected core %0d",
                     c, ramstate, (order_q.size() > 0) ? order_q[0] : -1);
          end else if (is_wr[c]) begin
            n_checks++;
            if ({ramWEN, ramaddr, ramstore} !== {1'b1, ea, wdata[c][wcnt[c]]}) begin
              n_fail++;
              $display("FAIL wb_word: got wen=%b addr=%h data=%h expected 1 %h %h",
                       ramWEN, ramaddr, ramstore, ea, wdata[c][wcnt[c]]);
            end
          end else begin
            n_checks++;
            if ({ramREN, ramaddr, dload[32*c +: 32]} !== {1'b1, ea, ea ^ RAM_KEY}) begin
              n_fail++;
              $display("FAIL fill_word: core %0d got ren=%b addr=%h data=%h expected 1 %h %h",
                       c, ramREN, ramaddr, dload[32*c +: 32], ea, ea ^ RAM_KEY);
            end
          end
          if (order_q.size() > 0 && c == order_q[0]) begin
            wcnt[c]++;
            if (wcnt[c] == BW) begin
              active[c] = 1'b0; wcnt[c] = 0; last_d = c;
              void'(order_q.pop_front());
            end
          end
        end
      end
    end
    n_checks++;
    if (order_q.size() != 0) begin
      n_fail++;
      $display("FAIL round_timeout: %0d cores unserved, expected 0", order_q.size());
    end
    @(posedge CLK); #1;
    drive_inputs();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({ramREN, ramWEN, ramaddr} !== 34'h0) begin
      n_fail++; $display("FAIL reset_ram: got %b %b %h expected 0 0 0", ramREN, ramWEN, ramaddr);
    end
    n_checks++;
    if ({iwait, dwait} !== 4'b1111) begin
      n_fail++; $display("FAIL reset_wait: got %b expected 1111", {iwait, dwait});
    end
    n_checks++;
    if ({ccwait, ccinv} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_cc: got %b expected 0000", {ccwait, ccinv});
    end
    n_checks++;
    if ({iwait4, dwait4, ramREN4, ramWEN4} !== 10'b11111111_00) begin
      n_fail++; $display("FAIL reset_dut4: got %b expected 1111111100", {iwait4, dwait4, ramREN4, ramWEN4});
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({ramREN, ramWEN, dwait} !== 4'b0011) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 0011", {ramREN, ramWEN, dwait});
    end
  endtask

  task automatic test_two_reads();
    clear_cores();
    rs_mode = 0;
    active[0] = 1'b1; base[0] = 32'h0000_0040;
    active[1] = 1'b1; base[1] = 32'h0000_0080;
    run_data_round(40);
  endtask

  task automatic test_write_busy();
    clear_cores();
    rs_mode = 1; busy_run = 0;
    active[0] = 1'b1; is_wr[0] = 1'b1; base[0] = 32'h200;
    wdata[0][0] = 32'h11; wdata[0][1] = 32'h22;
    run_data_round(60);
    n_checks++;
    if (wr_acc != 2) begin
      n_fail++; $display("FAIL wb_access_count: got %0d expected 2", wr_acc);
    end
  endtask

  task automatic test_c2c();
    int cyc = 0;
    int k = 0;
    bit snooped = 1'b0;
    clear_cores();
    rs_mode = 0;
    active[1] = 1'b1; ccw[1] = 1'b1; cct[1] = 1'b1; base[1] = 32'h100;
    ccw[0] = 1'b1; base[0] = 32'h100;
    wdata[0][0] = 32'hDEADBEEF; wdata[0][1] = 32'hFEEDF00D;
    while (k < 2 && cyc < 40) begin
      @(posedge CLK); #1;
      drive_inputs();
      @(negedge CLK);
      cyc++;
      if (ccwait[0] && !snooped) begin
        snooped = 1'b1;
        n_checks++;
        if ({ccinv[0], ccsnoopaddr[31:0], ccwait[1], ramREN, ramWEN} !== {1'b1, 32'h100, 3'b000}) begin
          n_fail++;
          $display("FAIL snoop: got inv=%b addr=%h wait1=%b ren=%b wen=%b expected 1 100 0 0 0",
                   ccinv[0], ccsnoopaddr[31:0], ccwait[1], ramREN, ramWEN);
        end
      end
      if (!dwait[1]) begin
        n_checks++;
        if ({dload[63:32], dwait[0], ccwait[0]} !== {wdata[0][k], 1'b0, 1'b1}) begin
          n_fail++;
          $display("FAIL c2c_data: got %h dwait0=%b ccwait0=%b expected %h 0 1",
                   dload[63:32], dwait[0], ccwait[0], wdata[0][k]);
        end
        n_checks++;
        if ({ramWEN, ramaddr, ramstore} !== {1'b1, 32'h100 + k, wdata[0][k]}) begin
          n_fail++;
          $display("FAIL c2c_ram: got %b %h %h expected 1 %h %h",
                   ramWEN, ramaddr, ramstore, 32'h100 + k, wdata[0][k]);
        end
        k++; wcnt[0]++; wcnt[1]++;
      end
    end
    n_checks++;
    if (!snooped || k != 2) begin
      n_fail++; $display("FAIL c2c_done: snooped=%b words=%0d expected 1 2", snooped, k);
    end
    clear_cores();
    last_d = 1;
    @(posedge CLK); #1;
    drive_inputs();
  endtask

  task automatic test_priority();
    int cyc = 0;
    int dl = 0;
    bit fetched = 1'b0;
    clear_cores();
    rs_mode = 0;
    active[1] = 1'b1; base[1] = 32'h400;
    iaddr[31:0] = 32'h500;
    while (!fetched && cyc < 50) begin
      @(posedge CLK); #1;
      drive_inputs();
      iREN[0] = 1'b1;
      @(negedge CLK);
      cyc++;
      if (!dwait[1]) begin
        dl++; wcnt[1]++;
        if (wcnt[1] == BW) begin active[1] = 1'b0; wcnt[1] = 0; last_d = 1; end
      end
      if (!iwait[0]) begin
        fetched = 1'b1;
        n_checks++;
        if (dl != 2) begin
          n_fail++; $display("FAIL fetch_order: data words before fetch %0d expected 2", dl);
        end
        n_checks++;
        if ({ramREN, ramaddr, iload[31:0]} !== {1'b1, 32'h500, 32'h500 ^ RAM_KEY}) begin
          n_fail++;
          $display("FAIL fetch_word: got %b %h %h expected 1 00000500 %h",
                   ramREN, ramaddr, iload[31:0], 32'h500 ^ RAM_KEY);
        end
      end
    end
    n_checks++;
    if (!fetched) begin
      n_fail++; $display("FAIL fetch_timeout: fetched=%b expected 1", fetched);
    end
    @(posedge CLK); #1;
    iREN = 2'b00;
    drive_inputs();
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    bit seen = 1'b0;
    clear_cores();
    rs_mode = 0;
    active[0] = 1'b1; base[0] = 32'h300;
    active[1] = 1'b1; base[1] = 32'h340;
    while (!seen && cyc < 30) begin
      @(posedge CLK); #1;
      drive_inputs();
      @(negedge CLK);
      cyc++;
      seen = (dwait !== 2'b11);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (!seen || ramREN !== 1'b1) begin
      n_fail++; $display("FAIL mid_block: seen=%b ramREN=%b expected 1 1", seen, ramREN);
    end
    nRST = 1'b0;
    #1;
    n_checks++;
    if ({ramREN, ramWEN, dwait, iwait, ccwait} !== 8'b00_11_11_00) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 00111100", {ramREN, ramWEN, dwait, iwait, ccwait});
    end
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    last_d = 1; wcnt[0] = 0; wcnt[1] = 0;
    run_data_round(40);
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      clear_cores();
      rs_mode = 2;
      for (int c = 0; c < 2; c++) begin
        active[c] = 1'($urandom_range(0, 1));
        is_wr[c]  = 1'($urandom_range(0, 1));
        cct[c]    = !is_wr[c] && ($urandom_range(0, 1) == 1);
        base[c]   = is_wr[c] ? 32'h8000 + 16 * $urandom_range(0, 255) : 16 * $urandom_range(0, 255);
        for (int w = 0; w < 8; w++) wdata[c][w] = $urandom;
      end
      if (!active[0] && !active[1]) active[r % 2] = 1'b1;
      run_data_round(200);
    end
  endtask

  task automatic test_four_core();
    int k = 0;
    int cyc = 0;
    int w4 [4] = '{0, 0, 0, 0};
    logic [31:0] ea;
    while (k < 20 && cyc < 600) begin
      @(posedge CLK); #1;
      dREN4 = 4'hF;
      for (int c = 0; c < 4; c++) daddr4[32*c +: 32] = 32'h1000 + 16 * c + w4[c];
      ramstate4 = ($urandom_range(0, 3) != 0) ? ACCESS : BUSY;
      @(negedge CLK);
      cyc++;
      for (int c = 0; c < 4; c++) begin
        if (!dwait4[c] && k < 20) begin
          ea = 32'h1000 + 16 * c + w4[c];
          n_checks++;
          if (c != (k / 4) % 4) begin
            n_fail++; $display("FAIL rr4_order: word %0d went to core %0d expected core %0d", k, c, (k / 4) % 4);
          end
          n_checks++;
          if (dload4[32*c +: 32] !== (ea ^ RAM_KEY)) begin
            n_fail++; $display("FAIL rr4_data: core %0d got %h expected %h", c, dload4[32*c +: 32], ea ^ RAM_KEY);
          end
          w4[c] = (w4[c] + 1) % 4;
          k++;
        end
      end
    end
    n_checks++;
    if (k < 20) begin
      n_fail++; $display("FAIL rr4_timeout: got %0d words expected 20", k);
    end
    @(posedge CLK); #1;
    dREN4 = 4'h0;
  endtask

  initial begin
    nRST = 1'b0;
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    cctrans = '0; ccwrite = '0; ramstate = FREE;
    iREN4 = '0; iaddr4 = '0; dREN4 = '0; dWEN4 = '0; daddr4 = '0; dstore4 = '0;
    cctrans4 = '0; ccwrite4 = '0; ramstate4 = FREE;
    for (int c = 0; c < 2; c++) for (int w = 0; w < 8; w++) wdata[c][w] = 32'h0;
    clear_cores();
    last_d = 1; rs_mode = 0; busy_run = 0; wr_acc = 0;

    test_reset();
    test_two_reads();
    test_write_busy();
    test_c2c();
    test_priority();
    test_reset_mid();
    test_random();
    test_four_core();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
